// File: rtl/hv_unary_decoder.sv
// hv_unary_decoder: per-lane ones counter that turns a stream of unary
// (thermometer-coded) hypervector beats back into binary lane levels.
// One count vector per FRAME_LEN beats is presented over valid/ready, with
// the result register separate from the accumulators so the next frame
// can be collected while the previous result waits for the consumer.
module hv_unary_decoder #(
    parameter int DIM       = 64,
    parameter int FRAME_LEN = 144,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [DIM-1:0]       hv_in,
    input  logic                 hv_valid,
    output logic                 hv_ready,
    output logic [DIM*CNT_W-1:0] cnt_out,
    output logic [DIM-1:0]       maj_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     beat_idx
);

    // The accumulators must hold a full frame of ones without wrapping.
    if ((2 ** CNT_W) <= FRAME_LEN) begin : g_cnt_w_check
        $error("hv_unary_decoder: CNT_W too small, need 2**CNT_W > FRAME_LEN");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(FRAME_LEN / 2);

    // EMPTY: no result held; FULL: cnt_out/maj_out hold an unconsumed frame.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_idx_q, beat_idx_d;

    logic last_beat;
    logic accept;
    logic complete;
    logic consume;

    // Handshake qualifiers. Only the final beat of a frame can stall, and only
    // while the held result has not been taken; clr wins over any accept.
    assign last_beat = (beat_idx_q == LAST_IDX);
    assign out_valid = (state_q == FULL);
    assign hv_ready  = !(last_beat && out_valid && !out_ready);
    assign accept    = hv_valid && hv_ready && !clr;
    assign complete  = accept && last_beat;
    assign consume   = out_valid && out_ready;
    assign beat_idx  = beat_idx_q;

    // Next-state logic: a completing frame refills the output even when the
    // old result is consumed on the same edge.
    always_comb begin
        state_d = state_q;
        if (complete) begin
            state_d = FULL;
        end else if (consume) begin
            state_d = EMPTY;
        end
    end

    // Beat position within the frame; wraps on completion, clears on abort.
    always_comb begin
        beat_idx_d = beat_idx_q;
        if (clr || complete) begin
            beat_idx_d = '0;
        end else if (accept) begin
            beat_idx_d = beat_idx_q + 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            beat_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic [CNT_W-1:0] acc_q, acc_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             maj_q, maj_d;
        logic [CNT_W-1:0] sum;

        // Lane update: the final beat's bit is folded straight into the
        // result so the count is ready one cycle after the last beat.
        always_comb begin
            sum   = acc_q + CNT_W'(hv_in[gi]);
            acc_d = acc_q;
            cnt_d = cnt_q;
            maj_d = maj_q;
            if (clr) begin
                acc_d = '0;
            end else if (complete) begin
                acc_d = '0;
                cnt_d = sum;
                maj_d = (sum > HALF);
            end else if (accept) begin
                acc_d = sum;
            end
        end

        // Lane accumulator and held result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
                cnt_q <= '0;
                maj_q <= 1'b0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                maj_q <= maj_d;
            end
        end

        assign cnt_out[gi*CNT_W +: CNT_W] = cnt_q;
        assign maj_out[gi]                = maj_q;
    end

endmodule

// File: doc/hv_unary_decoder.md
Name: hv_unary_decoder

Overview:
- Inverse of the scalar-to-HV comparator encoder. Accepts a stream of DIM-bit hypervector beats, one per threshold step.
- Accumulates the number of ones per dimension over FRAME_LEN beats, which recovers each lane's scalar level as a binary count.
- Emits one registered count vector per frame over a valid/ready handshake. Feeds the classifier and debug readback path.

Parameters:
- DIM, 64, number of hypervector lanes (bits per beat).
- FRAME_LEN, 144, beats per frame (number of thresholds).
- CNT_W, 8, per-lane count width. Must satisfy 2^CNT_W > FRAME_LEN; elaboration-time assertion otherwise.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort of the frame in progress.
- hv_in  in  DIM  hypervector beat; bit i belongs to lane i.
- hv_valid  in  1  beat present.
- hv_ready  out  1  decoder can accept a beat.
- cnt_out  out  DIM*CNT_W  result; lane i occupies bits [i*CNT_W +: CNT_W].
- maj_out  out  DIM  per-lane majority bit: 1 iff count > FRAME_LEN/2 (integer division).
- out_valid  out  1  cnt_out/maj_out hold a completed frame.
- out_ready  in  1  downstream accepts the result.
- beat_idx  out  CNT_W  beats accepted in the current frame (0..FRAME_LEN-1).

Behaviour:
- Reset (async, rst=1): accumulators, beat_idx, cnt_out, maj_out and out_valid all go to 0. hv_ready=1 once rst is deasserted.
- Beat accept: hv_valid && hv_ready at posedge.
  - Each lane accumulator adds hv_in[i] (0 or 1).
  - beat_idx increments.
- Frame completion: accept while beat_idx == FRAME_LEN-1.
  - Next cycle: cnt_out = accumulator + hv_in[i] for every lane; maj_out derived from those counts; out_valid=1.
  - Accumulators and beat_idx clear to 0 on the same edge.
  - Latency: 1 cycle from the final beat accepted to out_valid high.
- Double buffering: the output register is separate from the accumulators, so the next frame accumulates while the result is held.
- hv_ready = !(beat_idx == FRAME_LEN-1 && out_valid && !out_ready). Only the final beat of a frame stalls, and only while an unconsumed result is pending.
- Output handshake:
  - out_valid && out_ready at posedge clears out_valid, unless a new frame completes on the same edge. In that case out_valid stays 1 and cnt_out/maj_out load the new frame.
  - cnt_out and maj_out are stable while out_valid && !out_ready.
- clr=1:
  - Clears accumulators and beat_idx; any beat presented that cycle is discarded.
  - Does not touch out_valid, cnt_out or maj_out.
  - clr has priority over a simultaneous beat accept, including a final beat.
- Arithmetic: accumulators never overflow given the CNT_W constraint. No saturation logic required.
- hv_valid low: no state change except output handshake and clr.
- FSM: two states, derived from out_valid.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; moves to EMPTY on consume without a coincident completion.
  - All transitions follow the rules above.
- Reset mid-frame: partial counts are discarded; the next accepted beat is beat 0.

Test Plan:
- All-ones: hv_in=all 1s for 144 consecutive beats, out_ready=1 → out_valid high 1 cycle after the last beat; every lane count = 144; maj_out = all 1s; beat_idx back to 0.
- Thermometer recovery: bit i of beat j = (j < 2*i) → lane i count = min(2*i, 144), e.g. lane 5 = 10, lane 63 = 126. maj_out[i] = 1 for i ≥ 37 (2*i > 72).
- Backpressure: out_ready=0 after frame 1; stream frame 2 → hv_ready drops exactly at beat_idx=143. Raise out_ready → frame 1 consumed, beat 143 accepted the same cycle, frame 2 result appears the next cycle.
- Simultaneous consume and complete: out_ready=1 on the edge frame 2's last beat is accepted → out_valid stays 1 continuously and cnt_out switches to frame 2 values.
- clr at beat 70 with hv_in=all 1s → next frame of 144 all-zero beats yields all counts = 0. A previously held result remains valid and unchanged until consumed.
- Async rst asserted mid-frame (beat 50, out_valid=1) → out_valid, cnt_out and beat_idx go to 0 immediately without a clock edge. A following full frame of all 1s gives counts of 144.
